r88_mem_sched: RTL

R88_MEM_SCHED -- requirements
Module: r88_mem_sched

---
 rtl/r88_mem_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/r88_mem_sched.sv
// r88_mem_sched: arbitrates a read-only fetch port and a read/write data port
// onto a single memory controller.
// A fetch drives its address directly on regAddr; a data access first ships
// its address over the internal byte bus (low byte, then high byte), then
// performs the read or write.
// Optional feature macro: R88_MEM_SCHED_RR_EN selects round-robin arbitration
// between the two ports. When it is undefined, the data port always wins.
module r88_mem_sched (
    input  logic        sysClock,
    input  logic        sysReset_n,
    input  logic        fReq,
    input  logic [15:0] fAddr,
    output logic        fAck,
    output logic [7:0]  fData,
    input  logic        dReq,
    input  logic        dWe,
    input  logic [15:0] dAddr,
    input  logic [7:0]  dWdata,
    output logic        dAck,
    output logic [7:0]  dRdata,
    input  logic        memWait,
    output logic        readMem,
    output logic        writeMem,
    output logic        mc_use_regAddr,
    output logic        mc_write_low,
    output logic        mc_write_high,
    output logic [15:0] regAddr,
    output logic [7:0]  intD_out,
    output logic        intD_oe,
    input  logic [7:0]  intD_in,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR_LO = 3'd1,
        ADDR_HI = 3'd2,
        ACCESS  = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t      state;
    state_t      nextState;
    logic        servingData;   // port of the transaction in flight: 1 = data
    logic        grantData;
    logic        grantAny;
    logic [15:0] addrLatch;
    logic        weLatch;
    logic [7:0]  wdataLatch;

    assign grantAny = fReq | dReq;

`ifdef R88_MEM_SCHED_RR_EN
    logic lastWasData;          // reset to 0 so data wins the first contention

    assign grantData = dReq & (~fReq | ~lastWasData);

    // Remember which port completed last; updated only in RESP
    always_ff @(posedge sysClock or negedge sysReset_n) begin
        if (!sysReset_n) begin
            lastWasData <= 1'b0;
        end else if (state == RESP) begin
            lastWasData <= servingData;
        end
    end
`else
    assign grantData = dReq;
`endif

    // State, granted port and the architecturally visible result registers
    always_ff @(posedge sysClock or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state       <= IDLE;
            servingData <= 1'b0;
            regAddr     <= 16'h0000;
            fData       <= 8'h00;
            dRdata      <= 8'h00;
        end else begin
            state <= nextState;
            if (state == IDLE && grantAny) begin
                servingData <= grantData;
                if (!grantData) begin
                    regAddr <= fAddr;
                end
            end
            // Read data is captured on the edge that leaves ACCESS
            if (state == ACCESS && !memWait && !weLatch) begin
                if (servingData) begin
                    dRdata <= intD_in;
                end else begin
                    fData <= intD_in;
                end
            end
        end
    end

    // Request fields frozen at grant; later changes on the ports are ignored
    always_ff @(posedge sysClock) begin
        if (state == IDLE && grantAny) begin
            addrLatch  <= grantData ? dAddr : fAddr;
            weLatch    <= grantData & dWe;
            wdataLatch <= dWdata;
        end
    end

    // Next-state decode and per-state controller strobes
    always_comb begin
        nextState      = IDLE;
        readMem        = 1'b0;
        writeMem       = 1'b0;
        mc_use_regAddr = 1'b0;
        mc_write_low   = 1'b0;
        mc_write_high  = 1'b0;
        intD_out       = 8'h00;
        intD_oe        = 1'b0;
        fAck           = 1'b0;
        dAck           = 1'b0;
        case (state)
            IDLE: begin
                if (grantAny) begin
                    nextState = grantData ? ADDR_LO : ACCESS;
                end
            end
            ADDR_LO: begin
                nextState    = ADDR_HI;
                intD_out     = addrLatch[7:0];
                intD_oe      = 1'b1;
                mc_write_low = 1'b1;
            end
            ADDR_HI: begin
                nextState     = ACCESS;
                intD_out      = addrLatch[15:8];
                intD_oe       = 1'b1;
                mc_write_high = 1'b1;
            end
            ACCESS: begin
                nextState = memWait ? ACCESS : RESP;
                if (!servingData) begin
                    mc_use_regAddr = 1'b1;
                    readMem        = 1'b1;
                end else if (weLatch) begin
                    writeMem = 1'b1;
                    intD_out = wdataLatch;
                    intD_oe  = 1'b1;
                end else begin
                    readMem = 1'b1;
                end
            end
            RESP: begin
                nextState = IDLE;
                fAck      = ~servingData;
                dAck      = servingData;
            end
            default: nextState = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
